// File: rtl/regfile_sb_if.sv
// Register file bus: decode-side reads and issue marking, writeback-side writes.
//   master : drives rd_en/rd_addr, wr_*, iss_*, flush; observes rd_data, rd_busy, busy_cnt
//   slave  : the register file itself
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) ();

  logic                       rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_busy;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       iss_en;
  logic [ADDR_W-1:0]          iss_addr;
  logic                       flush;
  logic [ADDR_W:0]            busy_cnt;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/regfile_sb.sv
// Parametrised GPR file with registered read ports, write-to-read bypass,
// hardwired-zero r0 and a per-register pending-write scoreboard.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (overrides all other inputs)
//   bus  - regfile_sb_if.slave: reads, writeback write, issue marking,
//          flush, registered rd_data/rd_busy and busy_cnt
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  busy_cnt_d;
  logic              cnt_inc;
  logic              cnt_dec;

  // Register storage; r0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        mem_q[ADDR_W'(r)] <= '0;
      end
    end else if (bus.wr_en && (bus.wr_addr != '0)) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard next state: flush beats issue, issue beats writeback
  always_comb begin
    busy_d = busy_q;
    if (bus.flush) begin
      busy_d = '0;
    end else begin
      if (bus.wr_en)  busy_d[bus.wr_addr]  = 1'b0;
      if (bus.iss_en) busy_d[bus.iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Pending count tracks clear->set and set->clear transitions only
  always_comb begin
    cnt_inc = bus.iss_en && (bus.iss_addr != '0) && !busy_q[bus.iss_addr];
    cnt_dec = bus.wr_en && (bus.wr_addr != '0) && busy_q[bus.wr_addr] &&
              !(bus.iss_en && (bus.iss_addr == bus.wr_addr));
    if (bus.flush) begin
      busy_cnt_d = '0;
    end else begin
      busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

  // Per read port: zero/bypass/array select, busy reflects post-edge state
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd_data_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_busy_q;

    assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

    assign rd_data_d = (ra == '0) ? '0 :
                       (bus.wr_en && (bus.wr_addr == ra)) ? bus.wr_data :
                       mem_q[ra];

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q <= '0;
        rd_busy_q <= 1'b0;
      end else if (bus.rd_en) begin
        rd_data_q <= rd_data_d;
        rd_busy_q <= busy_d[ra];
      end
    end

    assign bus.rd_data[k*DATA_W +: DATA_W] = rd_data_q;
    assign bus.rd_busy[k]                  = rd_busy_q;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the pipelined MIPS core, replacing the fixed 32x32 two-read-port file. It provides N registered read ports, one write port with same-cycle write-to-read bypass, a hardwired-zero register 0, and an integrated per-register pending-write scoreboard that decode uses to detect RAW hazards and stall. It sits between decode (reads, issue marking) and writeback (writes, pending clear).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- rd_en  in  1  sample all read ports this cycle
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  registered pending flag per read port
- wr_en  in  1  writeback write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- iss_en  in  1  issue strobe: mark iss_addr as pending
- iss_addr  in  ADDR_W  destination register of issued instruction
- flush  in  1  clear all pending flags (pipeline flush)
- busy_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Reset (rst=1 at clk edge): all registers 0, all busy bits 0, rd_data 0, rd_busy 0, busy_cnt 0. rst overrides every other input that cycle.
- Write: wr_en=1 and wr_addr!=0 -> mem[wr_addr] <= wr_data at edge. Writes to address 0 dropped; mem[0] always reads 0.
- Read: rd_en=1 -> for each port k, at edge rd_data[k] <= 0 if rd_addr[k]==0; else wr_data if wr_en && wr_addr==rd_addr[k] (bypass); else mem[rd_addr[k]]. rd_en=0 -> rd_data and rd_busy hold. Reads independent of wr_en (no read-disable during writes).
- Scoreboard next-state busy_n per register r (r!=0), priority order:
  - flush=1 -> busy_n[r]=0 for all r; iss_en ignored that cycle.
  - else iss_en && iss_addr==r -> busy_n[r]=1 (new producer wins over same-cycle writeback).
  - else wr_en && wr_addr==r -> busy_n[r]=0.
  - else busy_n[r]=busy[r].
  - busy[0] constant 0; iss_en with iss_addr=0 has no effect.
- rd_busy[k] <= busy_n[rd_addr[k]] when rd_en=1 (reflects the state after this edge's updates, so a same-cycle writeback clears and a same-cycle issue sets).
- busy_cnt maintained as counter: +1 when a clear bit becomes set, -1 when a set bit is cleared by writeback, 0 on flush; simultaneous issue(set of a clear reg) and writeback(clear of a different set reg) -> unchanged. Issue to an already-busy register: no change. Writeback to a non-busy register: no change. Never exceeds 2**ADDR_W-1.

## Timing
- Read latency 1 cycle: address at edge n, data valid after edge n.
- Write visible to non-bypassed read sampled at edge n+1 when written at edge n; same-edge read returns new data via bypass.
- Scoreboard update and busy_cnt update at same edge as issue/writeback/flush.
- Multiple ports reading same address return identical data and busy.
- No combinational path from inputs to outputs.

## Test plan
- Reset: preload regs, assert rst one cycle -> next cycle read of r1..r31 returns 0, rd_busy=0, busy_cnt=0.
- Write/read: write r5=0xDEADBEEF at edge 1, read r5 on port 0 at edge 2 -> rd_data[0]=0xDEADBEEF; port 1 reading r6 (unwritten) -> 0.
- Bypass and r0: same edge wr r7=0x1234 and read r7 on both ports -> both 0x1234; write r0=0xFFFFFFFF then read r0 -> 0.
- Scoreboard: issue r3 -> read r3 busy=1, busy_cnt=1; same edge issue r3 and wb r3 -> busy stays 1, cnt 1; wb r3 alone -> busy 0, cnt 0; issue r4 with wb r9 (not busy) -> cnt 1.
- Flush: issue r2,r3,r4 on successive edges (cnt=3), then flush with iss_en on r8 -> all busy 0, cnt 0, r8 not busy.
- NUM_RD=3, DATA_W=64, ADDR_W=4: write r15=64'h0123456789ABCDEF, read ports at r15/r0/r15 with rd_en, then rd_en=0 with changed addresses -> outputs hold previous values.
